quad_pe_seq: RTL
================

# quad_pe_seq

Sequencer that drives one quad multiply-accumulate PE, the 4-lane MAC that clears on `pe_en`, accumulates every cycle and pulses `pe_valid` one cycle after `pe_finish`. It accepts packed 4-byte IFM/weight groups from an upstream stream and splits each tile of `cfg_len` groups into PE beats. It generates the PE's `pe_en` and `pe_finish` framing, captures each `pe_ofm` result and returns results downstream through a valid/ready port with a 2-entry result FIFO. It sits between the line-buffer/weight fetch logic and the output writer in the PE cluster.

## Interface
- `LEN_W`, default 8: width of the `cfg_len` and `cfg_tiles` counters.
- `clk`, input, 1: clock, rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: single-cycle job start. Sampled only in IDLE.
- `cfg_len`, input, LEN_W: groups per tile (1..2^LEN_W-1). Latched on `start`.
- `cfg_tiles`, input, LEN_W: tiles (results) per job. Latched on `start`.
- `busy`, output, 1: job in progress.
- `done`, output, 1: one-cycle pulse when the last result of a job is pushed into the FIFO.
- `s_valid`, input, 1: upstream group valid.
- `s_ready`, output, 1: upstream group accepted when high together with `s_valid`.
- `s_ifm`, input, 32: four IFM bytes. [7:0] is lane 1 and [31:24] is lane 4.
- `s_wgt`, input, 32: four weight bytes, same lane order as `s_ifm`.
- `pe_ifm1`..`pe_ifm4`, output, 8 each: PE IFM operands, registered.
- `pe_wgt1`..`pe_wgt4`, output, 8 each: PE weight operands, registered.
- `pe_en`, output, 1: registered. High on the first beat of a tile and clears the PE accumulator.
- `pe_finish`, output, 1: registered. High on the last beat of a tile.
- `pe_ofm`, input, 8: PE accumulator value.
- `pe_valid`, input, 1: PE result strobe.
- `m_valid`, output, 1: result available.
- `m_ready`, input, 1: downstream accepts the result.
- `m_data`, output, 8: result byte, head of the FIFO.

## Operation
- States:
  - IDLE:
    - `start` with `cfg_len`≠0 and `cfg_tiles`≠0 latches the config, clears `beat_cnt`/`tile_cnt` and moves to RUN.
    - `start` with a zero field is ignored.
  - RUN: accept beats.
    - `beat_cnt` counts 0..len-1 and wraps to 0 on the last beat.
    - `tile_cnt` increments at each wrap.
    - On the last beat of the last tile, move to DRAIN.
  - DRAIN: wait for the final `pe_valid`, then go to IDLE. `done` pulses on that push.
- `s_ready` is high in RUN only, and is additionally gated on the first beat of a tile (`beat_cnt`=0) by the credit rule:
  - Let `pending` = results issued (`pe_finish` sent) but not yet received via `pe_valid`.
  - Require `fifo_count` + `pending` < 2.
  - The credit is computed from the current-cycle values, including a pop this cycle (`m_valid`&`m_ready`).
- On each accepted beat, the next cycle drives:
  - `pe_ifm`/`pe_wgt` = the bytes of the beat.
  - `pe_en` = (`beat_cnt`==0).
  - `pe_finish` = (`beat_cnt`==len-1).
- `pe_en` and `pe_finish` are both high on the same beat when len=1.
- In any cycle with no accepted beat (stall, IDLE, DRAIN), all operands and `pe_en`/`pe_finish` are driven 0. Zero operands keep the PE accumulator unchanged, so upstream stalls mid-tile are lossless.
- When `pe_valid` is high, `pe_ofm` is pushed into the FIFO and `pending` decrements. The credit rule guarantees the FIFO is never full at a push.
- Arithmetic is modulo 256, as in the PE. This block does no arithmetic on data.
- `start` while `busy` is ignored.

## Timing
- Reset values:
  - `busy`, `done`, `s_ready`, `m_valid`, `pe_en`, `pe_finish` = 0.
  - All `pe_ifm*`/`pe_wgt*` = 0.
  - `m_data` = 0.
  - FIFO empty, `pending` = 0, state IDLE.
- `busy` goes high the cycle after `start` and low in the cycle after `done`.
- Latency, with the last beat accepted at edge T:
  - `pe_finish` is high in cycle T..T+1.
  - `pe_valid` is high in T+1..T+2 and is sampled at edge T+2.
  - `m_valid` goes high after edge T+2 if the FIFO was empty.
- Tiles stream back-to-back: the first beat of tile n+1 may be accepted at the edge right after the last beat of tile n, subject to credit.
- FIFO push and pop in the same cycle: the count is unchanged, and data order is preserved (FIFO order).
- Reset asserted mid-job:
  - Immediate return to reset values.
  - The PE framing signals drop to 0 asynchronously.
  - Partial results are discarded.

## Test plan
- len=1, tiles=1; ifm={1,2,3,4}, wgt={1,1,1,1}:
  - `pe_en`=`pe_finish`=1 in the same cycle.
  - `m_data`=10. `done` pulses once.
- len=3, tiles=1; groups {1,1,1,1}×{2,2,2,2} each, with `s_valid` low for 4 cycles between beats 1 and 2:
  - Operands are 0 during the stall.
  - `m_data`=24.
- Overflow: len=2, ifm={200,0,0,0}, wgt={2,0,0,0} on both beats:
  - `m_data`=(400+400) mod 256=32.
- Backpressure: `m_ready`=0, len=1, tiles=4:
  - Exactly 2 results are buffered, and `s_ready` stays 0 at the third tile's first beat.
  - Raising `m_ready` drains the results in order, and the job completes with 4 results.
- Control: `start` with `cfg_len`=0 leaves `busy` low. A second `start` during a job does not alter the latched `cfg_len`/`cfg_tiles`.
- `reset_n` low mid-tile (beat 2 of 4):
  - All outputs return to reset values and the FIFO is empty.
  - A new job after reset produces the correct, uncorrupted result.

Source files
------------

// File: rtl/quad_pe_seq.sv
// Sequencer for a 4-lane MAC PE: splits each tile of packed byte groups into PE beats,
// frames them with pe_en/pe_finish, and returns each tile result through a 2-entry FIFO.
module quad_pe_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [LEN_W-1:0] cfg_tiles,
  output logic             busy,
  output logic             done,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_ifm,
  input  logic [31:0]      s_wgt,
  output logic [7:0]       pe_ifm1,
  output logic [7:0]       pe_ifm2,
  output logic [7:0]       pe_ifm3,
  output logic [7:0]       pe_ifm4,
  output logic [7:0]       pe_wgt1,
  output logic [7:0]       pe_wgt2,
  output logic [7:0]       pe_wgt3,
  output logic [7:0]       pe_wgt4,
  output logic             pe_en,
  output logic             pe_finish,
  input  logic [7:0]       pe_ofm,
  input  logic             pe_valid,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] tiles_r;
  logic [LEN_W-1:0] beat_cnt_r;
  logic [LEN_W-1:0] tile_cnt_r;
  logic [1:0]       pending_r;
  logic [1:0]       fifo_cnt_r;
  logic [7:0]       fifo0_r;
  logic [7:0]       fifo1_r;
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic             busy_r;
  logic             done_r;

  logic             pop_s;
  logic             push_s;
  logic             credit_s;
  logic             first_beat_s;
  logic             last_beat_s;
  logic             last_tile_s;
  logic             accept_s;
  logic             start_ok_s;
  logic             final_push_s;
  logic [2:0]       occupancy_s;

  assign m_valid      = (fifo_cnt_r != 2'd0);
  assign m_data       = rd_ptr_r ? fifo1_r : fifo0_r;
  assign busy         = busy_r;
  assign done         = done_r;

  assign pop_s        = m_valid & m_ready;
  assign push_s       = pe_valid & ((fifo_cnt_r != 2'd2) | pop_s);
  // A new tile only starts if its result is guaranteed a FIFO slot when it returns.
  assign occupancy_s  = {1'b0, fifo_cnt_r} - {2'b00, pop_s} + {1'b0, pending_r};
  assign credit_s     = (occupancy_s < 3'd2);
  assign first_beat_s = (beat_cnt_r == {LEN_W{1'b0}});
  assign last_beat_s  = (beat_cnt_r == (len_r - {{(LEN_W-1){1'b0}}, 1'b1}));
  assign last_tile_s  = (tile_cnt_r == (tiles_r - {{(LEN_W-1){1'b0}}, 1'b1}));
  assign s_ready      = (state_r == ST_RUN) & (~first_beat_s | credit_s);
  assign accept_s     = s_valid & s_ready;
  assign start_ok_s   = (state_r == ST_IDLE) & start &
                        (cfg_len != {LEN_W{1'b0}}) & (cfg_tiles != {LEN_W{1'b0}});
  assign final_push_s = (state_r == ST_DRAIN) & pe_valid & (pending_r == 2'd1);

  // Job FSM, beat/tile counters and registered PE operand/framing drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      len_r      <= {LEN_W{1'b0}};
      tiles_r    <= {LEN_W{1'b0}};
      beat_cnt_r <= {LEN_W{1'b0}};
      tile_cnt_r <= {LEN_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pe_ifm1    <= 8'd0;
      pe_ifm2    <= 8'd0;
      pe_ifm3    <= 8'd0;
      pe_ifm4    <= 8'd0;
      pe_wgt1    <= 8'd0;
      pe_wgt2    <= 8'd0;
      pe_wgt3    <= 8'd0;
      pe_wgt4    <= 8'd0;
      pe_en      <= 1'b0;
      pe_finish  <= 1'b0;
    end else begin
      // Zero operands on idle cycles leave the PE accumulator untouched.
      if (accept_s) begin
        pe_ifm1   <= s_ifm[7:0];
        pe_ifm2   <= s_ifm[15:8];
        pe_ifm3   <= s_ifm[23:16];
        pe_ifm4   <= s_ifm[31:24];
        pe_wgt1   <= s_wgt[7:0];
        pe_wgt2   <= s_wgt[15:8];
        pe_wgt3   <= s_wgt[23:16];
        pe_wgt4   <= s_wgt[31:24];
        pe_en     <= first_beat_s;
        pe_finish <= last_beat_s;
      end else begin
        pe_ifm1   <= 8'd0;
        pe_ifm2   <= 8'd0;
        pe_ifm3   <= 8'd0;
        pe_ifm4   <= 8'd0;
        pe_wgt1   <= 8'd0;
        pe_wgt2   <= 8'd0;
        pe_wgt3   <= 8'd0;
        pe_wgt4   <= 8'd0;
        pe_en     <= 1'b0;
        pe_finish <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) begin
            len_r      <= cfg_len;
            tiles_r    <= cfg_tiles;
            beat_cnt_r <= {LEN_W{1'b0}};
            tile_cnt_r <= {LEN_W{1'b0}};
            state_r    <= ST_RUN;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (accept_s && last_beat_s) begin
            beat_cnt_r <= {LEN_W{1'b0}};
            tile_cnt_r <= tile_cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
            state_r    <= last_tile_s ? ST_DRAIN : ST_RUN;
          end else if (accept_s) begin
            beat_cnt_r <= beat_cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
          end else begin
            state_r    <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          state_r <= final_push_s ? ST_IDLE : ST_DRAIN;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      done_r <= final_push_s;
      if (start_ok_s) begin
        busy_r <= 1'b1;
      end else if (done_r) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  // Outstanding-result tracking and the 2-entry result FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r  <= 2'd0;
      fifo_cnt_r <= 2'd0;
      fifo0_r    <= 8'd0;
      fifo1_r    <= 8'd0;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
    end else begin
      case ({accept_s & last_beat_s, pe_valid & (pending_r != 2'd0)})
        2'b10:   pending_r <= pending_r + 2'd1;
        2'b01:   pending_r <= pending_r - 2'd1;
        default: pending_r <= pending_r;
      endcase

      if (push_s) begin
        if (wr_ptr_r) begin
          fifo1_r <= pe_ofm;
        end else begin
          fifo0_r <= pe_ofm;
        end
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end

      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

endmodule
